ssemi_fir_coeff_loader: RTL and testbench

SSEMI_FIR_COEFF_LOADER -- requirements
Module: ssemi_fir_coeff_loader

---
 rtl/ssemi_fir_coeff_loader.sv | 139 +++++++++++++
 tb/tb_ssemi_fir_coeff_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ssemi_fir_coeff_loader.sv
// FIR coefficient loader: shadow tap set written at random, then snapshotted
// and presented to the filter with a valid/ready handshake and a timeout.
module ssemi_fir_coeff_loader #(
  parameter int NUM_TAPS       = 64,
  parameter int COEFF_WIDTH    = 18,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int AW            = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_enable,
  input  logic                            i_wr_en,
  input  logic [AW-1:0]                   i_wr_addr,
  input  logic [COEFF_WIDTH-1:0]          i_wr_data,
  input  logic                            i_commit,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] o_coeff,
  output logic                            o_coeff_valid,
  input  logic                            i_coeff_ready,
  output logic [NUM_TAPS-1:0]             o_wr_mask,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_timeout,
  output logic                            o_err_incomplete,
  output logic                            o_err_addr,
  output logic [1:0]                      o_state
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  REQ     = 2'd1;
  localparam logic [1:0]  DONE    = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [COEFF_WIDTH-1:0]          shadow [NUM_TAPS];
  logic [NUM_TAPS*COEFF_WIDTH-1:0] shadow_flat;
  logic [NUM_TAPS-1:0]             wr_bit;
  logic [NUM_TAPS-1:0]             mask_next;
  logic [15:0]                     cnt;
  logic                            wr_ok;
  logic                            accept;
  logic                            timeout_hit;

  assign wr_ok = i_wr_en && (32'(i_wr_addr) < NUM_TAPS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      assign wr_bit[gi] = wr_ok && (i_wr_addr == AW'(gi));
      assign shadow_flat[gi*COEFF_WIDTH +: COEFF_WIDTH] = shadow[gi];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
          shadow[gi] <= '0;
        else if (wr_bit[gi])
          shadow[gi] <= i_wr_data;
      end
    end
  endgenerate

  assign accept      = i_enable && (o_state == IDLE) && i_commit && (&o_wr_mask);
  assign timeout_hit = i_enable && (o_state == REQ) && !i_coeff_ready && (cnt == TO_LAST);

  // A write coinciding with a commit lands after the mask clear.
  always_comb begin
    mask_next = o_wr_mask;
    if (accept)
      mask_next = '0;
    else if (timeout_hit)
      mask_next = '1;
    mask_next = mask_next | wr_bit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_state          <= IDLE;
      o_coeff          <= '0;
      o_coeff_valid    <= 1'b0;
      o_wr_mask        <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_timeout        <= 1'b0;
      o_err_incomplete <= 1'b0;
      o_err_addr       <= 1'b0;
      cnt              <= '0;
    end else begin
      o_done           <= 1'b0;
      o_timeout        <= 1'b0;
      o_err_incomplete <= 1'b0;
      o_err_addr       <= i_wr_en && !wr_ok;
      o_wr_mask        <= mask_next;
      if (!i_enable) begin
        o_state       <= IDLE;
        o_coeff_valid <= 1'b0;
        o_busy        <= 1'b0;
        cnt           <= '0;
      end else begin
        case (o_state)
          IDLE: begin
            if (i_commit) begin
              if (accept) begin
                o_coeff       <= shadow_flat;
                o_coeff_valid <= 1'b1;
                o_busy        <= 1'b1;
                cnt           <= '0;
                o_state       <= REQ;
              end else begin
                o_err_incomplete <= 1'b1;
              end
            end
          end
          REQ: begin
            if (i_coeff_ready) begin
              o_coeff_valid <= 1'b0;
              o_done        <= 1'b1;
              o_state       <= DONE;
            end else if (timeout_hit) begin
              o_coeff_valid <= 1'b0;
              o_busy        <= 1'b0;
              o_timeout     <= 1'b1;
              cnt           <= '0;
              o_state       <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DONE: begin
            o_busy  <= 1'b0;
            o_state <= IDLE;
          end
          default: begin
            o_coeff_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssemi_fir_coeff_loader.sv
// Randomized bench for ssemi_fir_coeff_loader against a cycle-level reference model
// built from the loader's write/commit/handshake/timeout rules.
module tb_ssemi_fir_coeff_loader;

  localparam int N  = 5;
  localparam int W  = 18;
  localparam int TO = 8;
  localparam int AW = $clog2(N);
  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_DONE = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0, we = 1'b0, commit = 1'b0, ready = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [W-1:0]    data = '0;
  logic [N*W-1:0]  coeff;
  logic [N-1:0]    mask;
  logic            valid, busy, done, tmo, err_inc, err_addr;
  logic [1:0]      state;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_coeff  [N];
  bit   [N-1:0] m_mask;
  int           m_state;
  int           m_req_cycles;
  bit           e_to, e_inc, e_addr;

  ssemi_fir_coeff_loader #(.NUM_TAPS(N), .COEFF_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_wr_en(we), .i_wr_addr(addr),
    .i_wr_data(data), .i_commit(commit), .o_coeff(coeff), .o_coeff_valid(valid),
    .i_coeff_ready(ready), .o_wr_mask(mask), .o_busy(busy), .o_done(done),
    .o_timeout(tmo), .o_err_incomplete(err_inc), .o_err_addr(err_addr), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = '0;
      m_coeff[k]  = '0;
    end
    m_mask = '0; m_state = S_IDLE; m_req_cycles = 0;
    e_to = 0; e_inc = 0; e_addr = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] nm;
    nm = m_mask;
    e_to = 0; e_inc = 0; e_addr = 0;
    if (!en) begin
      m_state = S_IDLE;
      m_req_cycles = 0;
    end else if (m_state == S_IDLE) begin
      if (commit) begin
        if (m_mask == '1) begin
          for (int k = 0; k < N; k++) m_coeff[k] = m_shadow[k];
          nm = '0;
          m_req_cycles = 0;
          m_state = S_REQ;
        end else begin
          e_inc = 1;
        end
      end
    end else if (m_state == S_REQ) begin
      m_req_cycles++;
      if (ready) begin
        m_state = S_DONE;
      end else if (m_req_cycles == TO) begin
        e_to = 1;
        nm = '1;
        m_state = S_IDLE;
      end
    end else begin
      m_state = S_IDLE;
    end
    if (we) begin
      if (int'(addr) < N) begin
        m_shadow[addr] = data;
        nm[addr] = 1'b1;
      end else begin
        e_addr = 1;
      end
    end
    m_mask = nm;
  endtask

  task automatic check_all();
    logic [N*W-1:0] ec;
    for (int k = 0; k < N; k++) ec[k*W +: W] = m_coeff[k];
    check("coeff",    128'(coeff),    128'(ec));
    check("valid",    128'(valid),    128'(m_state == S_REQ));
    check("mask",     128'(mask),     128'(m_mask));
    check("state",    128'(state),    128'(m_state));
    check("busy",     128'(busy),     128'(m_state != S_IDLE));
    check("done",     128'(done),     128'(m_state == S_DONE));
    check("timeout",  128'(tmo),      128'(e_to));
    check("err_inc",  128'(err_inc),  128'(e_inc));
    check("err_addr", 128'(err_addr), 128'(e_addr));
  endtask

  task automatic apply(input bit e, input bit w, input int a, input int d,
                       input bit c, input bit r);
    @(negedge clk);
    en = e; we = w; addr = AW'(a); data = W'(d); commit = c; ready = r;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic wr(input int a, input int d);
    apply(1, 1, a, d, 0, 0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, r);
  endtask

  task automatic fill();
    for (int k = 0; k < N; k++) wr(k, int'($urandom_range(0, (1 << W) - 1)));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    en = 1'b1; we = 1'b0; commit = 1'b0; ready = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3 check_all();
    @(negedge clk) rst = 1'b0;

    // incomplete set, then full set with ready after 3 cycles
    wr(0, 'h00001); wr(1, 'h3FFFF); wr(2, 'h20000); wr(3, 'h00010);
    apply(1, 0, 0, 0, 1, 0);
    wr(4, 'h0ABCD);
    apply(1, 0, 0, 0, 1, 0);
    idle(3, 0);
    idle(1, 1);
    idle(3, 0);

    // timeout then immediate recommit with ready
    fill();
    apply(1, 0, 0, 0, 1, 0);
    idle(TO, 0);
    apply(1, 0, 0, 0, 1, 1);
    idle(3, 1);

    // write during REQ, commit ignored in REQ, write coinciding with commit
    fill();
    apply(1, 1, 2, 'h11111, 1, 0);
    wr(1, 'h12345);
    apply(1, 0, 0, 0, 1, 0);
    idle(2, 1);
    apply(1, 0, 0, 0, 1, 0);

    // out-of-range writes
    for (int a = N; a < (1 << AW); a++) wr(a, 'h3AAAA);

    // reset mid-REQ
    fill();
    apply(1, 0, 0, 0, 1, 0);
    idle(2, 0);
    async_reset();
    idle(2, 1);

    // disable mid-REQ, commits ignored while disabled
    fill();
    apply(1, 0, 0, 0, 1, 0);
    idle(1, 0);
    apply(0, 0, 0, 0, 1, 1);
    apply(0, 1, 3, 'h00777, 1, 0);
    idle(2, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 19) != 0),
            $urandom_range(0, 1),
            int'($urandom_range(0, (1 << AW) - 1)),
            int'($urandom_range(0, (1 << W) - 1)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 2));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
